mem_access_ctrl: RTL
====================

# mem_access_ctrl

Initiator-side controller for the byte-addressed data RAM in the MEM stage of the pipelined core. It accepts one load/store request at a time from the pipeline over a valid/ready handshake and decodes RISC-V funct3 into the RAM's `mem_u_b_h_w` width code. It rejects misaligned, illegal or out-of-range accesses without touching the RAM, sequences the RAM ports for a configurable number of wait cycles, and returns read data and an error flag over a valid/ready response channel.

## Interface
- `WAIT_CYCLES`, default 1: cycles the RAM ports are held per access, ≥1.
- `MEM_BYTES`, default 128: RAM size in bytes, power of two; addresses ≥ `MEM_BYTES` are errors.
- `clk`  in  1: single clock; all state updates on posedge.
- `rst`  in  1: reset, synchronous, active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: controller can accept.
- `req_we`  in  1: 1 = store, 0 = load.
- `req_funct3`  in  3: RISC-V load/store funct3.
- `req_addr`  in  32: byte address.
- `req_wdata`  in  32: store data, right-aligned.
- `rsp_valid`  out  1: response present.
- `rsp_ready`  in  1: consumer accepts response.
- `rsp_rdata`  out  32: load data, already extended; 0 for stores and errors.
- `rsp_err`  out  1: access rejected.
- `ram_addra`  out  32: RAM address.
- `ram_dina`  out  32: RAM write data.
- `ram_wea`  out  1: RAM write enable; the RAM writes on the negedge of its cycle.
- `ram_mem_u_b_h_w`  out  3: bit0 = half, bit1 = word, bit2 = unsigned.
- `ram_douta`  in  32: combinational RAM read data.

## Operation
- Decode table, loads:
  - 000 LB → 000.
  - 001 LH → 001.
  - 010 LW → 010.
  - 100 LBU → 100.
  - 101 LHU → 101.
- Decode table, stores:
  - 000 SB → 000.
  - 001 SH → 001.
  - 010 SW → 010.
- Other funct3 values are illegal (loads: 011/110/111; stores: anything except 000–010).
- Error conditions: illegal funct3; half access with `addr[0]`=1; word access with `addr[1:0]`≠0; `addr` ≥ `MEM_BYTES`.
- States:
  - IDLE: `req_ready`=1. When `req_valid` is seen, latch we/addr/wdata/code/err. If err, go to RESP; otherwise go to ACCESS with cnt=0.
  - ACCESS: drive `ram_addra` = latched addr, `ram_dina` = latched wdata, `ram_mem_u_b_h_w` = latched code. cnt increments each cycle. On the cycle where cnt = `WAIT_CYCLES`-1, `ram_wea` = latched we, and for loads `ram_douta` is captured into rdata. The next state is RESP.
  - RESP: `rsp_valid`=1, and `rsp_rdata`/`rsp_err` are held stable. When `rsp_ready` is seen, go to IDLE.
- Outside ACCESS, all `ram_*` outputs are 0. `ram_wea` is never high outside the final ACCESS cycle.
- Errored requests never drive the RAM; they return `rsp_err`=1 with `rsp_rdata`=0.
- Sign/zero extension is performed by the RAM; `rsp_rdata` is `ram_douta` unmodified.

## Timing
- Reset: state IDLE, cnt 0, and every output is 0 while `rst` is high. `req_ready` rises the cycle after `rst` falls.
- Valid request accepted at edge N:
  - ACCESS in cycles N+1 … N+`WAIT_CYCLES`.
  - `rsp_valid` is high from cycle N+`WAIT_CYCLES`+1.
- Errored request accepted at edge N: `rsp_valid` is high in cycle N+1.
- Back-to-back: after a RESP handshake, IDLE lasts at least one cycle. Throughput is one request per `WAIT_CYCLES`+2 cycles.
- `req_ready` is 0 in ACCESS and RESP. Requests presented then are not taken.
- Reset during ACCESS before the final cycle leaves the RAM unwritten. Reset during RESP discards the response.
- `rsp_ready` held low keeps RESP indefinitely with data stable.

## Structure
- Shared package `mem_pkg`:
  - funct3 constants (`F3_LB` … `F3_SW`).
  - `mem_u_b_h_w` codes (`MW_B`, `MW_H`, `MW_W`, `MW_BU`, `MW_HU`).
  - state enum (IDLE/ACCESS/RESP).
- One combinational sub-module `mem_access_decode`: (we, funct3, addr) → (code, err). It is reusable by a later instruction-fetch initiator.

## Test plan
- Preload byte 0x10 = 0x80. LB 0x10 → `rsp_rdata`=0xFFFFFF80, err 0; LBU 0x10 → 0x00000080.
- SW 0x20 with wdata 0xDEADBEEF, then LW 0x20 → 0xDEADBEEF; LH 0x22 → 0xFFFFDEAD; LHU 0x22 → 0x0000DEAD. `ram_wea` is high exactly one cycle per store.
- LW 0x21, SH 0x23, and funct3 011 each → `rsp_err`=1, `rsp_rdata`=0, response one cycle after accept, `ram_wea` never high.
- SW 0x80 with `MEM_BYTES`=128 → err 1; RAM contents unchanged.
- `WAIT_CYCLES`=3, LW with `rsp_ready` low for 3 cycles → `rsp_valid` at accept+4, data held stable, `req_ready`=0 until the handshake.
- `WAIT_CYCLES`=3, SB 0x05 with wdata 0xAA, and `rst` asserted in the second ACCESS cycle → byte 0x05 unchanged, all outputs 0, IDLE after reset.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-RAM initiator: funct3 encodings, RAM width
// codes and the controller state enum.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // bit0 = half, bit1 = word, bit2 = unsigned
  localparam logic [2:0] MW_B  = 3'b000;
  localparam logic [2:0] MW_H  = 3'b001;
  localparam logic [2:0] MW_W  = 3'b010;
  localparam logic [2:0] MW_BU = 3'b100;
  localparam logic [2:0] MW_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_access_decode.sv
// Combinational funct3/address decode into a RAM width code plus an error flag
// covering illegal funct3, misalignment and out-of-range addresses.
module mem_access_decode
  import mem_pkg::*;
#(
  parameter int MEM_BYTES = 128
) (
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  output logic [2:0]  code,
  output logic        err
);

  logic legal;
  logic misaligned;

  always_comb begin
    code  = MW_B;
    legal = 1'b0;
    if (we) begin
      unique case (funct3)
        F3_SB: begin code = MW_B; legal = 1'b1; end
        F3_SH: begin code = MW_H; legal = 1'b1; end
        F3_SW: begin code = MW_W; legal = 1'b1; end
        default: begin code = MW_B; legal = 1'b0; end
      endcase
    end else begin
      unique case (funct3)
        F3_LB:  begin code = MW_B;  legal = 1'b1; end
        F3_LH:  begin code = MW_H;  legal = 1'b1; end
        F3_LW:  begin code = MW_W;  legal = 1'b1; end
        F3_LBU: begin code = MW_BU; legal = 1'b1; end
        F3_LHU: begin code = MW_HU; legal = 1'b1; end
        default: begin code = MW_B; legal = 1'b0; end
      endcase
    end
  end

  assign misaligned = (code[1] && (addr[1:0] != 2'b00)) || (code[0] && addr[0]);
  assign err        = !legal || misaligned || (addr >= 32'(MEM_BYTES));

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data RAM initiator: accepts one load/store, holds the RAM ports for
// WAIT_CYCLES cycles, then returns read data / error on a valid-ready response.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 1,
  parameter int MEM_BYTES   = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] ram_addra,
  output logic [31:0] ram_dina,
  output logic        ram_wea,
  output logic [2:0]  ram_mem_u_b_h_w,
  input  logic [31:0] ram_douta
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg;
  logic           we_reg;
  logic [31:0]    addr_reg;
  logic [31:0]    wdata_reg;
  logic [31:0]    rdata_reg;
  logic [2:0]     code_reg;
  logic           err_reg;
  logic [2:0]     dec_code;
  logic           dec_err;
  logic           last_beat;

  mem_access_decode #(.MEM_BYTES(MEM_BYTES)) u_decode (
    .we     (req_we),
    .funct3 (req_funct3),
    .addr   (req_addr),
    .code   (dec_code),
    .err    (dec_err)
  );

  assign last_beat = (state_reg == ACCESS) && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      code_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            we_reg    <= req_we;
            addr_reg  <= req_addr;
            wdata_reg <= req_wdata;
            code_reg  <= dec_code;
            err_reg   <= dec_err;
            rdata_reg <= '0;
            cnt_reg   <= '0;
          end
        end
        ACCESS: begin
          // Counter returns to 0 on the final beat so it rests at 0 outside ACCESS.
          cnt_reg <= last_beat ? '0 : cnt_reg + 1'b1;
          if (last_beat && !we_reg) rdata_reg <= ram_douta;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid) state_next = dec_err ? RESP : ACCESS;
      ACCESS:  if (last_beat) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Every output is forced low while reset is held, independent of state.
  always_comb begin
    req_ready       = 1'b0;
    rsp_valid       = 1'b0;
    rsp_rdata       = '0;
    rsp_err         = 1'b0;
    ram_addra       = '0;
    ram_dina        = '0;
    ram_wea         = 1'b0;
    ram_mem_u_b_h_w = '0;
    if (!rst) begin
      case (state_reg)
        IDLE: req_ready = 1'b1;
        ACCESS: begin
          ram_addra       = addr_reg;
          ram_dina        = wdata_reg;
          ram_mem_u_b_h_w = code_reg;
          ram_wea         = last_beat && we_reg;
        end
        RESP: begin
          rsp_valid = 1'b1;
          rsp_rdata = rdata_reg;
          rsp_err   = err_reg;
        end
        default: ;
      endcase
    end
  end

endmodule
